// File: rtl/display_select_bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : display_select_bcd                                         |
// | Description : Debug display selector for the CPU board. Routes one of    |
// |               NUM_CH statistics counters (as packed BCD, converted by an |
// |               iterative double-dabble engine), the latched main display  |
// |               word, or the memory-watch word to the 7-segment driver.    |
// | Option      : DISP_AUTOSCROLL_EN - switch all-ones steps through the     |
// |               counter channels every SCROLL_DIV clocks.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module display_select_bcd #(
    parameter int NUM_CH     = 3,
    parameter int CNT_W      = 32,
    parameter int DIGITS     = 8,
    parameter int SEL_W      = 4,
    parameter int SCROLL_DIV = 50000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      showA0,
    input  logic [31:0]               led_data,
    input  logic [NUM_CH*CNT_W-1:0]   cnt_flat,
    input  logic [31:0]               data_out,
    input  logic [SEL_W-1:0]          switch,
    output logic [31:0]               new_out,
    output logic                      busy,
    output logic                      ovf
);

    localparam int c_BCD_W    = 4 * DIGITS;
    localparam int c_BITCNT_W = $clog2(CNT_W);

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] f_max_val();
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    // Saturation display pattern: every produced digit shows 9.
    function automatic logic [31:0] f_nines();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'h9;
        end
        return v;
    endfunction

    localparam logic [63:0]           c_MAX_VAL  = f_max_val();
    localparam logic [31:0]           c_NINES    = f_nines();
    localparam logic [c_BITCNT_W-1:0] c_BIT_LAST = c_BITCNT_W'(CNT_W - 1);
    localparam logic [SEL_W-1:0]      c_SEL_LAST = SEL_W'(NUM_CH);
    localparam logic [SEL_W-1:0]      c_SEL_DATA = SEL_W'(NUM_CH + 1);

    // Parameter sanity guard: an illegal set elaborates g_cfg_invalid.
    if (((1 << SEL_W) < NUM_CH + 2) || (SCROLL_DIV < CNT_W + 4)) begin : g_cfg_invalid
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_is_cnt;
    logic [CNT_W-1:0]        w_ch_val;
    logic                    w_ch_over;
    logic [CNT_W-1:0]        r_bin;
    logic [c_BCD_W-1:0]      r_bcd;
    logic [c_BCD_W-1:0]      w_adj;
    logic [c_BITCNT_W-1:0]   r_bit_cnt;
    logic                    r_sat;
    logic [SEL_W-1:0]        r_cur_sel;
    logic [31:0]             r_latch;

`ifdef DISP_AUTOSCROLL_EN
    localparam int c_DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCROLL_DIV - 1);

    logic                    w_scroll_mode;
    logic [c_DIV_W-1:0]      r_scroll_cnt;
    logic [SEL_W-1:0]        r_scroll_ch;

    assign w_scroll_mode = (switch == '1);

    // Scroll step counter: held at channel 1 / count 0 outside scroll mode,
    // so entering the mode always starts a fresh slot on channel 1.
    always_ff @(posedge clk) begin
        if (!rst_n || !w_scroll_mode) begin
            r_scroll_cnt <= '0;
            r_scroll_ch  <= SEL_W'(1);
        end else if (r_scroll_cnt == c_DIV_LAST) begin
            r_scroll_cnt <= '0;
            r_scroll_ch  <= (r_scroll_ch == c_SEL_LAST) ? SEL_W'(1)
                                                        : r_scroll_ch + SEL_W'(1);
        end else begin
            r_scroll_cnt <= r_scroll_cnt + c_DIV_W'(1);
        end
    end

    assign w_sel = w_scroll_mode ? r_scroll_ch : switch;
`else
    assign w_sel = switch;
`endif

    assign w_is_cnt  = (w_sel != '0) && (w_sel <= c_SEL_LAST);
    assign w_ch_over = ({{(64-CNT_W){1'b0}}, w_ch_val} > c_MAX_VAL);
    assign busy      = (r_state == S_LOAD) || (r_state == S_SHIFT);

    // Channel multiplexer: value of the counter addressed by the active select.
    always_comb begin
        w_ch_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_sel == SEL_W'(k + 1)) begin
                w_ch_val = cnt_flat[k*CNT_W +: CNT_W];
            end
        end
    end

    // Double-dabble correction: add 3 to every BCD digit of 5 or more.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Converter next-state: a select change during LOAD/SHIFT restarts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_is_cnt) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = w_is_cnt ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                if (!w_is_cnt) begin
                    w_state_next = S_IDLE;
                end else if (w_sel != r_cur_sel) begin
                    w_state_next = S_LOAD;
                end else if (r_bit_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = w_is_cnt ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Conversion datapath: snapshot on LOAD, one shift-add-3 step per SHIFT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_sat     <= 1'b0;
            r_cur_sel <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_bin     <= w_ch_val;
                    r_bcd     <= '0;
                    r_bit_cnt <= c_BIT_LAST;
                    r_sat     <= w_ch_over;
                    r_cur_sel <= w_sel;
                end
                S_SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_bit_cnt      <= r_bit_cnt - c_BITCNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Main display latch, loaded by the showA0 strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_latch <= '0;
        end else if (showA0) begin
            r_latch <= led_data;
        end
    end

    // Output word: raw selects every cycle, converted value only on DONE
    // of a conversion whose channel is still the one selected.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            new_out <= '0;
            ovf     <= 1'b0;
        end else if (w_sel == '0) begin
            new_out <= showA0 ? led_data : r_latch;
            ovf     <= 1'b0;
        end else if (w_sel == c_SEL_DATA) begin
            new_out <= data_out;
            ovf     <= 1'b0;
        end else if (!w_is_cnt) begin
            new_out <= '0;
            ovf     <= 1'b0;
        end else if ((r_state == S_DONE) && (w_sel == r_cur_sel)) begin
            new_out <= r_sat ? c_NINES : 32'(r_bcd);
            ovf     <= r_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_select_bcd.sv
`default_nettype none
// Bench for display_select_bcd: raw-select vector table plus hand-written
// conversion, abort, reset and (optionally) auto-scroll sequences.
module tb_display_select_bcd;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 32;
    localparam int DIGITS     = 8;
    localparam int SEL_W      = 4;
    localparam int SCROLL_DIV = 100;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     showA0;
    logic [31:0]              led_data;
    logic [NUM_CH*CNT_W-1:0]  cnt_flat;
    logic [31:0]              data_out;
    logic [SEL_W-1:0]         switch;
    logic [31:0]              new_out;
    logic                     busy;
    logic                     ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] val;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    typedef struct packed {
        logic [3:0]  sw;
        logic        show;
        logic [31:0] led;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    display_select_bcd #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DIGITS     (DIGITS),
        .SEL_W      (SEL_W),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .showA0   (showA0),
        .led_data (led_data),
        .cnt_flat (cnt_flat),
        .data_out (data_out),
        .switch   (switch),
        .new_out  (new_out),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        cnt_flat[k*CNT_W +: CNT_W] = v;
    endtask

    task automatic push(input string name, input logic [31:0] v, input logic o);
        exp_t e;
        e.name = name;
        e.val  = v;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            e = sb.pop_front();
            chk({e.name, "_out"}, new_out, e.val);
            chk({e.name, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
        end
    endtask

    // Step edges until new_out changes; n = edges taken, -1 on timeout.
    task automatic wait_update(input int budget, output int n);
        logic [31:0] prev;
        prev = new_out;
        n    = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (new_out !== prev) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = '{4'd0,  1'b0, 32'hAAAA5555, 32'h00000000, 32'h00000000};
        vecs[1] = '{4'd0,  1'b1, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{4'd0,  1'b0, 32'h12345678, 32'h00000000, 32'hDEADBEEF};
        vecs[3] = '{4'd4,  1'b0, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[4] = '{4'd4,  1'b0, 32'h12345678, 32'h00000001, 32'h00000001};
        vecs[5] = '{4'd5,  1'b0, 32'h12345678, 32'h00000001, 32'h00000000};
        vecs[6] = '{4'd9,  1'b0, 32'h12345678, 32'h00000001, 32'h00000000};
        vecs[7] = '{4'd4,  1'b1, 32'h11112222, 32'h00000003, 32'h00000003};
        vecs[8] = '{4'd0,  1'b0, 32'h00000000, 32'h00000003, 32'h11112222};
        vecs[9] = '{4'd12, 1'b0, 32'h00000000, 32'h00000003, 32'h00000000};

        rst_n    = 1'b0;
        showA0   = 1'b0;
        led_data = '0;
        data_out = '0;
        cnt_flat = '0;
        switch   = '0;
        step(3);
        chk("rst_out",  new_out, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ovf",  {31'b0, ovf}, 32'h0);
        rst_n = 1'b1;

        // Raw selects: one-edge latency, latch and bypass behaviour.
        for (int i = 0; i < 10; i++) begin
            switch   = vecs[i].sw;
            showA0   = vecs[i].show;
            led_data = vecs[i].led;
            data_out = vecs[i].dat;
            push($sformatf("tbl%0d", i), vecs[i].exp, 1'b0);
            step(1);
            sb_pop();
            chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, 32'h0);
        end
        showA0 = 1'b0;

        // Channel 0 = 1234: enters LOAD next edge, result 34 edges later.
        set_ch(0, 32'd1234);
        switch = 4'd1;
        step(1);
        chk("conv_busy_load", {31'b0, busy}, 32'h1);
        push("conv_1234", 32'h00001234, 1'b0);
        wait_update(40, n);
        chk("conv_latency", 32'(n), 32'd34);
        sb_pop();

        // Refresh: new value sampled by the next LOAD, shown 34 edges on.
        set_ch(0, 32'd4321);
        step(33);
        chk("refresh_done_busy", {31'b0, busy}, 32'h0);
        chk("refresh_hold", new_out, 32'h00001234);
        step(1);
        push("refresh_4321", 32'h00004321, 1'b0);
        sb_pop();

        // Saturation on channel 2, then memory-watch clears ovf.
        set_ch(2, 32'd100000000);
        switch = 4'd3;
        push("sat", 32'h99999999, 1'b1);
        wait_update(40, n);
        chk("sat_latency", 32'(n), 32'd34);
        sb_pop();
        switch   = 4'd4;
        data_out = 32'h0BADF00D;
        push("watch", 32'h0BADF00D, 1'b0);
        step(1);
        sb_pop();
        step(2);

        // Abort: switch 1 -> 2 during SHIFT cycle 10; 5 must never appear.
        set_ch(0, 32'd5);
        set_ch(1, 32'd77);
        switch = 4'd1;
        step(11);
        chk("abort_busy_shift", {31'b0, busy}, 32'h1);
        switch = 4'd2;
        push("abort_77", 32'h00000077, 1'b0);
        wait_update(45, n);
        chk("abort_latency", 32'(n), 32'd35);
        sb_pop();

        // Saturate ch1, then reset during SHIFT cycle 20.
        set_ch(1, 32'hFFFFFFFF);
        push("sat_max", 32'h99999999, 1'b1);
        wait_update(40, n);
        chk("sat_max_latency", 32'(n), 32'd34);
        sb_pop();
        step(20);
        rst_n = 1'b0;
        step(1);
        chk("midrst_out",  new_out, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_ovf",  {31'b0, ovf}, 32'h0);
        rst_n = 1'b1;
        step(1);
        chk("restart_busy", {31'b0, busy}, 32'h1);
        step(5);
        set_ch(1, 32'd12);
        push("restart_sat", 32'h99999999, 1'b1);
        wait_update(40, n);
        chk("restart_latency", 32'(n), 32'd29);
        sb_pop();

`ifdef DISP_AUTOSCROLL_EN
        // Auto-scroll: channels 1,2,3,1 in SCROLL_DIV-cycle slots.
        set_ch(0, 32'd1);
        set_ch(1, 32'd2);
        set_ch(2, 32'd3);
        switch = 4'hF;
        step(60);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("scroll%0d", k), 32'(k % 3 + 1), 1'b0);
            sb_pop();
            step(SCROLL_DIV);
        end
`else
        // Without auto-scroll, all-ones is just an invalid select.
        switch = 4'hF;
        push("allones", 32'h0, 1'b0);
        step(1);
        sb_pop();
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
